// File: rtl/clkgen_multi.sv
// clkgen_multi: NCH independent divided clocks from one reference clock, each
// with programmable period/high time, glitch-free start/stop and a global sync.

module clkgen_chan #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sync,
  input  logic [DIVW-1:0] div,
  input  logic [DIVW-1:0] hi,
  output logic            clk_out,
  output logic            rise,
  output logic            running
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [DIVW-1:0] zero_c    = {DIVW{1'b0}};
  localparam logic [DIVW-1:0] one_c     = DIVW'(32'd1);
  localparam logic [DIVW-1:0] div_min_c = DIVW'(32'd2);

  state_t          state_r, state_s;
  logic [DIVW-1:0] cnt_r, cnt_s;
  logic [DIVW-1:0] div_l_r, div_l_s;
  logic [DIVW-1:0] hi_l_r, hi_l_s;
  logic [DIVW-1:0] div_eff_s, hi_eff_s;
  logic            load_s;
  logic            boundary_s;
  logic            clk_out_r, clk_out_s;
  logic            rise_r, rise_s;
  logic            running_r, running_s;

  function automatic logic [DIVW-1:0] clamp_div(input logic [DIVW-1:0] d);
    if (d < div_min_c) begin
      clamp_div = div_min_c;
    end else begin
      clamp_div = d;
    end
  endfunction

  // High time is forced into [1, div_eff-1] so every period has both levels.
  function automatic logic [DIVW-1:0] clamp_hi(input logic [DIVW-1:0] h,
                                               input logic [DIVW-1:0] d_eff);
    if (h == zero_c) begin
      clamp_hi = one_c;
    end else if (h >= d_eff) begin
      clamp_hi = d_eff - one_c;
    end else begin
      clamp_hi = h;
    end
  endfunction

  // Clamped view of the live configuration, only used when latching.
  always_comb begin
    div_eff_s = clamp_div(div);
    hi_eff_s  = clamp_hi(hi, div_eff_s);
  end

  // Next state, counter and latched configuration.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    load_s     = 1'b0;
    boundary_s = sync || (cnt_r == (div_l_r - one_c));
    case (state_r)
      ST_IDLE: begin
        cnt_s = zero_c;
        if (en) begin
          state_s = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (boundary_s) begin
          cnt_s = zero_c;
          if (en) begin
            state_s = ST_RUN;
            load_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + one_c;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = zero_c;
      end
    endcase
    if (load_s) begin
      div_l_s = div_eff_s;
      hi_l_s  = hi_eff_s;
    end else begin
      div_l_s = div_l_r;
      hi_l_s  = hi_l_r;
    end
  end

  // Output values for the next cycle, derived from the next-state view.
  always_comb begin
    if (state_s == ST_RUN) begin
      clk_out_s = (cnt_s < hi_l_s);
      rise_s    = load_s;
      running_s = 1'b1;
    end else begin
      clk_out_s = 1'b0;
      rise_s    = 1'b0;
      running_s = 1'b0;
    end
  end

  // State and output registers; reset drops clk_out without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= zero_c;
      div_l_r   <= div_min_c;
      hi_l_r    <= one_c;
      clk_out_r <= 1'b0;
      rise_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      div_l_r   <= div_l_s;
      hi_l_r    <= hi_l_s;
      clk_out_r <= clk_out_s;
      rise_r    <= rise_s;
      running_r <= running_s;
    end
  end

  assign clk_out = clk_out_r;
  assign rise    = rise_r;
  assign running = running_r;

endmodule

// Output invariants: a rise is always a high cycle, a high cycle is always running.
module clkgen_multi_chk #(
  parameter int NCH = 4
) (
  input logic           clk,
  input logic           rst,
  input logic [NCH-1:0] clk_out,
  input logic [NCH-1:0] rise,
  input logic [NCH-1:0] running
);

  for (genvar g = 0; g < NCH; g++) begin : g_chk
    a_rise_high: assert property (@(posedge clk) disable iff (rst) rise[g] |-> clk_out[g]);
    a_high_run:  assert property (@(posedge clk) disable iff (rst) clk_out[g] |-> running[g]);
  end

endmodule

module clkgen_multi #(
  parameter int NCH  = 4,
  parameter int DIVW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]      en,
  input  logic [NCH*DIVW-1:0] div,
  input  logic [NCH*DIVW-1:0] hi,
  input  logic              sync,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      rise,
  output logic [NCH-1:0]      running
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clkgen_chan #(.DIVW(DIVW)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .div     (div[g*DIVW +: DIVW]),
      .hi      (hi[g*DIVW +: DIVW]),
      .clk_out (clk_out[g]),
      .rise    (rise[g]),
      .running (running[g])
    );
  end

  clkgen_multi_chk #(.NCH(NCH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .clk_out (clk_out),
    .rise    (rise),
    .running (running)
  );

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed, table-driven bench for clkgen_multi (NCH=4, DIVW=8).

module tb_clkgen_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [31:0] div;
  logic [31:0] hi;
  logic        sync;
  logic [3:0]  clk_out;
  logic [3:0]  rise;
  logic [3:0]  running;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] div;
    logic [31:0] hi;
    logic        sync;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_rise;
    logic [3:0]  exp_run;
  } vec_t;

  vec_t vecs[$];

  clkgen_multi #(.NCH(4), .DIVW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div     (div),
    .hi      (hi),
    .sync    (sync),
    .clk_out (clk_out),
    .rise    (rise),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input logic [3:0] c, input logic [3:0] r,
                        input logic [3:0] u);
    check({name, " clk_out"}, clk_out, c);
    check({name, " rise"}, rise, r);
    check({name, " running"}, running, u);
  endtask

  task automatic add_vec(input logic [3:0] e, input logic [31:0] d, input logic [31:0] h,
                         input logic s, input logic [3:0] c, input logic [3:0] r,
                         input logic [3:0] u);
    vec_t v;
    v.en = e; v.div = d; v.hi = h; v.sync = s;
    v.exp_clk = c; v.exp_rise = r; v.exp_run = u;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // ch0: div=4 hi=2, hi->3 mid-period, stop cancelled, then real stop
    add_vec(4'b0001, 32'h04, 32'h02, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h02, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h02, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h02, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h02, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h02, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add_vec(4'b0000, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0000, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add_vec(4'b0001, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add_vec(4'b0000, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0000, 32'h04, 32'h03, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add_vec(4'b0000, 32'h04, 32'h03, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add_vec(4'b0000, 32'h04, 32'h03, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    add_vec(4'b0000, 32'h04, 32'h03, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ch1: div=6 hi=3, en dropped at cnt=1
    add_vec(4'b0010, 32'h0600, 32'h0300, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add_vec(4'b0010, 32'h0600, 32'h0300, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    add_vec(4'b0000, 32'h0600, 32'h0300, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    for (int i = 0; i < 3; i++)
      add_vec(4'b0000, 32'h0600, 32'h0300, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    add_vec(4'b0000, 32'h0600, 32'h0300, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ch2: div=0 hi=0 clamps to period 2, waveform 1,0
    add_vec(4'b0100, 32'h0, 32'h0, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add_vec(4'b0100, 32'h0, 32'h0, 1'b0, 4'b0000, 4'b0000, 4'b0100);
    add_vec(4'b0100, 32'h0, 32'h0, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add_vec(4'b0100, 32'h0, 32'h0, 1'b0, 4'b0000, 4'b0000, 4'b0100);
    add_vec(4'b0000, 32'h0, 32'h0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ch3: div=10 hi=10 clamps to 9 high, 1 low
    add_vec(4'b1000, 32'h0A000000, 32'h0A000000, 1'b0, 4'b1000, 4'b1000, 4'b1000);
    for (int i = 0; i < 8; i++)
      add_vec(4'b1000, 32'h0A000000, 32'h0A000000, 1'b0, 4'b1000, 4'b0000, 4'b1000);
    add_vec(4'b1000, 32'h0A000000, 32'h0A000000, 1'b0, 4'b0000, 4'b0000, 4'b1000);
    add_vec(4'b1000, 32'h0A000000, 32'h0A000000, 1'b0, 4'b1000, 4'b1000, 4'b1000);

    rst = 1'b1; en = 4'b0000; div = 32'h0; hi = 32'h0; sync = 1'b0;
    #1;
    check3("reset", 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; div = vecs[i].div; hi = vecs[i].hi; sync = vecs[i].sync;
      @(posedge clk); #1;
      check3($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_rise, vecs[i].exp_run);
    end

    // Reset mid-high on all channels, release with en held high
    rst = 1'b1; en = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    div = 32'h04040404; hi = 32'h02020202; en = 4'b1111;
    @(posedge clk); #1;
    check3("all_start", 4'b1111, 4'b1111, 4'b1111);
    #2 rst = 1'b1;
    #1;
    check3("async_rst", 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    check3("in_rst", 4'b0000, 4'b0000, 4'b0000);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check3("post_rst0", 4'b1111, 4'b1111, 4'b1111);
    @(posedge clk); #1;
    check3("post_rst1", 4'b1111, 4'b0000, 4'b1111);
    @(posedge clk); #1;
    check3("post_rst2", 4'b0000, 4'b0000, 4'b1111);

    // sync aligns ch0 (div 3) and ch1 (div 6) started on different edges
    rst = 1'b1; en = 4'b0000;
    #1;
    check3("rst2", 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    div = 32'h0603; hi = 32'h0301; en = 4'b0001;
    @(posedge clk); #1;
    check3("sync_a", 4'b0001, 4'b0001, 4'b0001);
    en = 4'b0011;
    @(posedge clk); #1;
    check3("sync_b", 4'b0010, 4'b0010, 4'b0011);
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    check3("sync_edge", 4'b0011, 4'b0011, 4'b0011);
    for (int k = 1; k <= 14; k++) begin
      int c0, c1;
      logic [3:0] ec, er;
      c0 = k % 3;
      c1 = k % 6;
      ec = {2'b00, (c1 < 3), (c0 < 1)};
      er = {2'b00, (c1 == 0), (c0 == 0)};
      @(posedge clk); #1;
      check3($sformatf("aligned%0d", k), ec, er, 4'b0011);
    end
    // ch0 is at cnt=div-1 here: sync and wrap form one boundary
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    check3("sync_wrap", 4'b0011, 4'b0011, 4'b0011);
    @(posedge clk); #1;
    check3("sync_wrap1", 4'b0010, 4'b0000, 4'b0011);
    en = 4'b0000; sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    check3("sync_stop", 4'b0000, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkgen_multi.md
# clkgen_multi

Multi-channel, synthesizable clock-pattern generator for testbenches and FPGA bring-up rigs. It derives NCH independent divided outputs from one reference clock. Each output has a programmable period and high time, plus a glitch-free start and stop. Outputs are held low while disabled. A global sync input phase-aligns all running channels. It replaces delay-based clock generation wherever a cycle-exact, reset-aware clock relationship is required.

## Interface
Parameters:
- NCH, 4, number of output channels (1..32)
- DIVW, 8, width of the per-channel period and high-time fields (2..16)

Ports:
- clk  in  1  reference clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  NCH  per-channel enable; bit i controls channel i
- div  in  NCH*DIVW  period in clk cycles; channel i uses bits [i*DIVW +: DIVW]
- hi  in  NCH*DIVW  high time in clk cycles; same packing as div
- sync  in  1  single-cycle restart of all running channels
- clk_out  out  NCH  generated clocks, registered
- rise  out  NCH  one-cycle strobe, high in the cycle clk_out[i] goes high
- running  out  NCH  channel i is in RUN

## Operation
- Each channel has a state machine with two states, IDLE and RUN.
- Each channel has a counter cnt[DIVW-1:0] and latched configuration div_l and hi_l.
- Configuration is sampled only at a period boundary, so a change to div or hi never produces a short pulse.
- A period boundary is one of three events:
  - entry to RUN;
  - an edge where cnt == div_l-1;
  - an edge where sync is high while the channel is in RUN.
- Clamping is applied when div and hi are latched:
  - div < 2 becomes 2;
  - hi == 0 becomes 1;
  - hi >= div_eff becomes div_eff-1.
  - Every running channel therefore toggles, with at least one high cycle and one low cycle per period.
- IDLE -> RUN occurs on an edge where en[i] is high.
  - cnt is set to 0, and div and hi are latched.
  - clk_out[i] is set to 1, rise[i] to 1 and running[i] to 1.
- In RUN, cnt increments on every edge that is not a boundary.
- clk_out[i] is registered as (cnt_next < hi_l_next).
- At a boundary in RUN with en[i] high:
  - cnt is set to 0 and the configuration is reloaded;
  - clk_out[i] is set to 1 and rise[i] is pulsed.
- At a boundary in RUN with en[i] low:
  - the channel goes to IDLE;
  - clk_out[i], rise[i] and running[i] are set to 0.
  - Dropping en mid-period therefore always completes the current period. No truncated high pulse is possible.
- In IDLE, clk_out, rise and running are 0, and cnt holds 0.
- sync has no effect on IDLE channels.
- sync together with cnt == div_l-1 is a single boundary, not two.
- sync together with en low ends the channel, as at any boundary.
- Channels are fully independent apart from sync.

## Timing
- Reset value of every output is 0.
- Reset puts every channel in IDLE with cnt = 0, div_l = 2 and hi_l = 1.
- Reset asserted mid-high forces clk_out low immediately, without waiting for a clock edge.
- The first edge after reset deassertion behaves as an ordinary IDLE-state edge.
- Latency from the edge sampling en high to clk_out high is 0 cycles: clk_out is high after that same edge.
- rise coincides with that edge and lasts exactly one cycle.
- Steady-state waveform:
  - clk_out is high for hi_eff cycles, then low for div_eff-hi_eff cycles;
  - rise pulses once per period, so its period is div_eff.
- Stop latency is at most div_l-1 cycles after en falls. running falls on the same edge as the final low cycle ends.
- en re-asserted before the final boundary cancels the stop: the channel continues with no gap.
- After sync, every running enabled channel is high on the following cycle with cnt = 0.
- Two channels whose periods are integer multiples of each other stay rise-aligned after sync.

## Test plan
- div=4, hi=2, en[0] held high -> clk_out[0] reads 1,1,0,0 repeating from the enabling edge; rise[0] pulses every 4th cycle; running[0] = 1.
- Running div=4, hi=2 with hi changed to 3 at cnt=1 -> the current period stays 1,1,0,0; the next period is 1,1,1,0.
- div=6, hi=3 with en dropped at cnt=1 -> the period completes as 1,1,1,0,0,0, then clk_out stays 0; running falls after the sixth cycle; no pulse shorter than 3 cycles appears.
- div=0, hi=0 -> the clamp produces a period of 2 and the waveform 1,0 repeating.
- div=10, hi=10 -> the clamp produces 9 high cycles and 1 low cycle.
- Channel 0 at div=3 and channel 1 at div=6, started on different edges, then a sync pulse -> both rise on the next cycle, and rise[0] fires on every 2nd channel-0 period aligned with rise[1].
- Reset asserted mid-high on all 4 channels -> clk_out, rise and running are 0 immediately.
- After reset is released with en still high -> every channel restarts with cnt = 0, with its first rise on the first edge after deassertion.
